// File: rtl/s_tx_channel_arbiter.sv
// ---------------------------------------------------------------------------
// s_tx_channel_arbiter
//
// Merges the AW request stream (write header + data) and the AR request
// stream (single-beat read header) into one packet stream for the link layer.
// Arbitration is round-robin and packet-atomic: once a source wins, it keeps
// the grant until its last beat. The per-packet sidebands (connection id,
// byte count, source) are captured from the first beat of each packet.
// A single register stage drives every tx output.
//
// Ports
//   clk_i, reset_i                clock, asynchronous active-high reset
//   aw_channel_*_i / _o           AW stream: data, keep, last, connection id,
//                                 byte count, valid in, ready out
//   ar_channel_*_i / _o           AR stream, same layout as AW
//   tx_*_o, tx_ready_i            merged output stream; tx_src_o 0=AW, 1=AR
//   pkt_len_err_o                 sticky; a packet ran past MAX_BEATS beats
//
// Build option
//   S_TX_ARB_STAT_EN  adds aw_pkt_cnt_o / ar_pkt_cnt_o, 32-bit wrapping
//                     counters of packets delivered per source.
// ---------------------------------------------------------------------------
module s_tx_channel_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BEATS  = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [DATA_WIDTH*8-1:0] aw_channel_i,
  input  logic [DATA_WIDTH-1:0]   aw_channel_keep_i,
  input  logic                    aw_channel_last_i,
  input  logic [3:0]              aw_channel_connection_id_i,
  input  logic [12:0]             aw_channel_byte_num_i,
  input  logic                    aw_channel_valid_i,
  output logic                    aw_channel_ready_o,
  input  logic [DATA_WIDTH*8-1:0] ar_channel_i,
  input  logic [DATA_WIDTH-1:0]   ar_channel_keep_i,
  input  logic                    ar_channel_last_i,
  input  logic [3:0]              ar_channel_connection_id_i,
  input  logic [12:0]             ar_channel_byte_num_i,
  input  logic                    ar_channel_valid_i,
  output logic                    ar_channel_ready_o,
  output logic [DATA_WIDTH*8-1:0] tx_data_o,
  output logic [DATA_WIDTH-1:0]   tx_keep_o,
  output logic                    tx_last_o,
  output logic [3:0]              tx_connection_id_o,
  output logic [12:0]             tx_byte_num_o,
  output logic                    tx_src_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic                    pkt_len_err_o
`ifdef S_TX_ARB_STAT_EN
  ,
  output logic [31:0]             aw_pkt_cnt_o,
  output logic [31:0]             ar_pkt_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK_AW = 2'd1,
    LOCK_AR = 2'd2
  } state_e;

  localparam logic [7:0] MAX_BEATS_C = 8'(MAX_BEATS);

  state_e                  state_q, state_d;
  logic                    rr_last_q, rr_last_d;      // 1 = AR won the last packet
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic                    err_q, err_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH*8-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0]   tx_keep_q, tx_keep_d;
  logic                    tx_last_q, tx_last_d;
  logic [3:0]              tx_cid_q, tx_cid_d;
  logic [12:0]             tx_bn_q, tx_bn_d;
  logic                    tx_src_q, tx_src_d;

  logic                    load_en_s;
  logic                    grant_aw_s, grant_ar_s;
  logic                    sel_valid_s, sel_last_s, accept_s;
  logic [DATA_WIDTH*8-1:0] sel_data_s;
  logic [DATA_WIDTH-1:0]   sel_keep_s;
  logic [3:0]              sel_cid_s;
  logic [12:0]             sel_bn_s;
  logic [7:0]              beat_num_s;

  // Grant: decided combinationally in IDLE so packets follow back to back;
  // fixed to the owner while locked, whatever the other side presents.
  always_comb begin
    load_en_s  = ~tx_valid_q | tx_ready_i;
    grant_aw_s = 1'b0;
    grant_ar_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (aw_channel_valid_i && ar_channel_valid_i) begin
          grant_ar_s = ~rr_last_q;
          grant_aw_s = rr_last_q;
        end else if (ar_channel_valid_i) begin
          grant_ar_s = 1'b1;
        end else if (aw_channel_valid_i) begin
          grant_aw_s = 1'b1;
        end else begin
          grant_aw_s = 1'b0;
          grant_ar_s = 1'b0;
        end
      end
      LOCK_AW: grant_aw_s = 1'b1;
      LOCK_AR: grant_ar_s = 1'b1;
      default: begin
        grant_aw_s = 1'b0;
        grant_ar_s = 1'b0;
      end
    endcase
  end

  // Source mux and handshake for the granted input.
  always_comb begin
    sel_data_s  = grant_ar_s ? ar_channel_i               : aw_channel_i;
    sel_keep_s  = grant_ar_s ? ar_channel_keep_i          : aw_channel_keep_i;
    sel_last_s  = grant_ar_s ? ar_channel_last_i          : aw_channel_last_i;
    sel_cid_s   = grant_ar_s ? ar_channel_connection_id_i : aw_channel_connection_id_i;
    sel_bn_s    = grant_ar_s ? ar_channel_byte_num_i      : aw_channel_byte_num_i;
    sel_valid_s = (grant_aw_s & aw_channel_valid_i) | (grant_ar_s & ar_channel_valid_i);
    accept_s    = sel_valid_s & load_en_s;
  end

  assign aw_channel_ready_o = grant_aw_s & load_en_s;
  assign ar_channel_ready_o = grant_ar_s & load_en_s;

  // Next state for the FSM, the beat counter and the output register.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_keep_d  = tx_keep_q;
    tx_last_d  = tx_last_q;
    tx_cid_d   = tx_cid_q;
    tx_bn_d    = tx_bn_q;
    tx_src_d   = tx_src_q;

    // Index of the beat being accepted now (1-based); IDLE means packet start.
    if (state_q == IDLE) begin
      beat_num_s = 8'd1;
    end else if (beat_cnt_q == 8'hFF) begin
      beat_num_s = 8'hFF;
    end else begin
      beat_num_s = beat_cnt_q + 8'd1;
    end

    if (load_en_s) begin
      tx_valid_d = accept_s;
    end else begin
      tx_valid_d = tx_valid_q;
    end

    if (accept_s) begin
      tx_data_d  = sel_data_s;
      tx_keep_d  = sel_keep_s;
      tx_last_d  = sel_last_s;
      beat_cnt_d = beat_num_s;
      // Any beat past MAX_BEATS flags the packet; the beat is still forwarded.
      err_d      = err_q | (beat_num_s > MAX_BEATS_C);
      if (state_q == IDLE) begin
        tx_cid_d = sel_cid_s;
        tx_bn_d  = sel_bn_s;
        tx_src_d = grant_ar_s;
      end else begin
        tx_cid_d = tx_cid_q;
        tx_bn_d  = tx_bn_q;
        tx_src_d = tx_src_q;
      end
      if (sel_last_s) begin
        state_d   = IDLE;
        rr_last_d = grant_ar_s;
      end else begin
        state_d   = grant_ar_s ? LOCK_AR : LOCK_AW;
        rr_last_d = rr_last_q;
      end
    end else if ((state_q != IDLE) && (state_q != LOCK_AW) && (state_q != LOCK_AR)) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // FSM, arbitration history, beat counter and registered output stage.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      beat_cnt_q <= 8'd0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_keep_q  <= '0;
      tx_last_q  <= 1'b0;
      tx_cid_q   <= 4'd0;
      tx_bn_q    <= 13'd0;
      tx_src_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_keep_q  <= tx_keep_d;
      tx_last_q  <= tx_last_d;
      tx_cid_q   <= tx_cid_d;
      tx_bn_q    <= tx_bn_d;
      tx_src_q   <= tx_src_d;
    end
  end

  assign tx_valid_o         = tx_valid_q;
  assign tx_data_o          = tx_data_q;
  assign tx_keep_o          = tx_keep_q;
  assign tx_last_o          = tx_last_q;
  assign tx_connection_id_o = tx_cid_q;
  assign tx_byte_num_o      = tx_bn_q;
  assign tx_src_o           = tx_src_q;
  assign pkt_len_err_o      = err_q;

`ifdef S_TX_ARB_STAT_EN
  logic [31:0] aw_cnt_q, aw_cnt_d;
  logic [31:0] ar_cnt_q, ar_cnt_d;
  logic        pkt_done_s;

  // Count packets as their last beat leaves the output register.
  always_comb begin
    pkt_done_s = tx_valid_q & tx_ready_i & tx_last_q;
    aw_cnt_d   = aw_cnt_q;
    ar_cnt_d   = ar_cnt_q;
    if (pkt_done_s && tx_src_q) begin
      ar_cnt_d = ar_cnt_q + 32'd1;
    end else if (pkt_done_s) begin
      aw_cnt_d = aw_cnt_q + 32'd1;
    end else begin
      aw_cnt_d = aw_cnt_q;
      ar_cnt_d = ar_cnt_q;
    end
  end

  // Packet counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      aw_cnt_q <= 32'd0;
      ar_cnt_q <= 32'd0;
    end else begin
      aw_cnt_q <= aw_cnt_d;
      ar_cnt_q <= ar_cnt_d;
    end
  end

  assign aw_pkt_cnt_o = aw_cnt_q;
  assign ar_pkt_cnt_o = ar_cnt_q;
`endif

endmodule
